// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parameterised synchronous FIFO.
package fifo_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    // Address width for a power-of-two depth. A single-entry store still needs one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// Handshake, data and status bundle between a FIFO user (master) and the FIFO (slave).
interface param_sync_fifo_if #(
    parameter int DATA_W = fifo_pkg::DEF_DATA_W,
    parameter int DEPTH  = fifo_pkg::DEF_DEPTH
);
    import fifo_pkg::*;

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic              err_clr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    modport master (
        output wr_en, wr_data, rd_en, err_clr,
        input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow, wr_ptr, rd_ptr
    );

    modport slave (
        input  wr_en, wr_data, rd_en, err_clr,
        output rd_data, rd_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow, wr_ptr, rd_ptr
    );

endinterface

// File: rtl/fifo_sdp_ram.sv
// Simple dual-port storage: one write port, one registered read port.
module fifo_sdp_ram
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [ptr_w(DEPTH)-1:0]  waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     re,
    input  logic [ptr_w(DEPTH)-1:0]  raddr,
    output logic [DATA_W-1:0]        rdata_p1
);

    logic [DATA_W-1:0] mem [DEPTH];

    // The array is deliberately left unreset; only rdata_p1 is observable.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read stage: output register only moves on an accepted read.
    always_ff @(posedge clk) begin
        if (rst)     rdata_p1 <= '0;
        else if (re) rdata_p1 <= mem[raddr];
    end

endmodule

// File: rtl/param_sync_fifo.sv
// Synchronous FIFO control: pointers, occupancy count, status flags and sticky errors.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2
) (
    input logic               clk,
    input logic               rst,
    param_sync_fifo_if.slave  bus
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LVL);
    localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LVL);

    // A fresh error in the clear cycle keeps the flag set.
    function automatic logic sticky_next(input logic cur, input logic set, input logic clr);
        return set | (cur & ~clr);
    endfunction

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;
    logic              vld_p1;
    logic [DATA_W-1:0] rd_data_p1;

    logic full;
    logic empty;
    logic wr_acc;
    logic rd_acc;
    logic ovf_evt;
    logic udf_evt;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign wr_acc  = bus.wr_en && !full && !rst;
    assign rd_acc  = bus.rd_en && !empty && !rst;
    assign ovf_evt = bus.wr_en && full;
    assign udf_evt = bus.rd_en && empty;

    fifo_sdp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .we       (wr_acc),
        .waddr    (wr_ptr),
        .wdata    (bus.wr_data),
        .re       (rd_acc),
        .raddr    (rd_ptr),
        .rdata_p1 (rd_data_p1)
    );

    // Control stage: pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            vld_p1    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_acc) rd_ptr <= rd_ptr + PTR_W'(1);
            unique case ({wr_acc, rd_acc})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            vld_p1    <= rd_acc;
            overflow  <= sticky_next(overflow, ovf_evt, bus.err_clr);
            underflow <= sticky_next(underflow, udf_evt, bus.err_clr);
        end
    end

    assign bus.rd_data      = rd_data_p1;
    assign bus.rd_valid     = vld_p1;
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count >= AF_CNT);
    assign bus.almost_empty = (count <= AE_CNT);
    assign bus.count        = count;
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;
    assign bus.wr_ptr       = wr_ptr;
    assign bus.rd_ptr       = rd_ptr;

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, number of entries; power of two, >=4.
REQ-003 Parameter AF_LVL, default DEPTH-2, almost_full threshold (1..DEPTH-1).
REQ-004 Parameter AE_LVL, default 2, almost_empty threshold (1..DEPTH-1, < AF_LVL).
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 wr_en  input  1  write request.
REQ-008 wr_data  input  DATA_W  write word.
REQ-009 rd_en  input  1  read request.
REQ-010 err_clr  input  1  clears sticky overflow/underflow.
REQ-011 rd_data  output  DATA_W  registered read word.
REQ-012 rd_valid  output  1  rd_data updated by read accepted on previous edge.
REQ-013 full / empty  output  1 each  occupancy == DEPTH / == 0.
REQ-014 almost_full / almost_empty  output  1 each  count >= AF_LVL / count <= AE_LVL.
REQ-015 count  output  $clog2(DEPTH)+1  current occupancy 0..DEPTH.
REQ-016 overflow / underflow  output  1 each  sticky error flags.
REQ-017 wr_ptr / rd_ptr  output  $clog2(DEPTH)  current write/read addresses.

Function
REQ-018 Write accepted iff wr_en && !full; word stored at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-019 Read accepted iff rd_en && !empty; rd_data <= mem[rd_ptr] on that edge, rd_ptr increments modulo DEPTH; one-cycle read latency.
REQ-020 rd_valid = 1 exactly in the cycle after an accepted read, else 0; rd_data holds its value when no read accepted.
REQ-021 count: +1 write-only, -1 read-only, unchanged when both or neither accepted.
REQ-022 Simultaneous wr_en && rd_en with 0 < count < DEPTH: both accepted, count unchanged, FIFO order preserved.
REQ-023 wr_en && rd_en while full: read accepted, write dropped, overflow set; count DEPTH-1 next cycle.
REQ-024 wr_en && rd_en while empty: write accepted, read rejected, underflow set; rd_valid 0.
REQ-025 wr_en while full (no read): write dropped, overflow set, memory/pointers unchanged.
REQ-026 rd_en while empty (no write): underflow set, rd_data holds, rd_ptr unchanged.
REQ-027 All flags decoded combinationally from registered count; they reflect an accepted operation in the cycle after its edge.
REQ-028 overflow/underflow remain 1 until err_clr or rst; a new error in the err_clr cycle keeps the flag set (set wins).

Reset
REQ-029 rst sampled high: wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, overflow=0, underflow=0, giving empty=1, almost_empty=1, full=0, almost_full=0.
REQ-030 rst has priority over wr_en/rd_en/err_clr in the same cycle; no write or read occurs.
REQ-031 Memory array is not reset; stale contents never visible because rd_data only updates on accepted reads.

Structure
REQ-032 Shared package fifo_pkg holds default DATA_W/DEPTH constants and a pointer-width helper function.
REQ-033 Storage in sub-module fifo_sdp_ram (one write port, one registered read port, DATA_W x DEPTH); control/counters in param_sync_fifo.

Verification (DATA_W=8, DEPTH=16, AF_LVL=14, AE_LVL=2)
REQ-034 Reset release -> empty=1, almost_empty=1, full=0, count=0, rd_valid=0.
REQ-035 Write 0x01..0x10 consecutively -> almost_empty falls at count 3, almost_full rises at count 14, full=1 at 16; 17th write (0xAA) -> overflow=1, count stays 16.
REQ-036 Read 16 consecutively -> rd_data 0x01..0x10 one cycle after each rd_en with rd_valid=1; empty=1; extra read -> underflow=1, rd_data holds 0x10, rd_valid=0; err_clr -> both sticky flags 0.
REQ-037 At count 8, wr_en && rd_en for 5 cycles -> count stays 8, output order intact; at full, both asserted -> count 15, overflow=1.
REQ-038 Interleaved 40 writes/reads with count 1..3 -> pointers wrap 15->0 at least twice, all 40 words read in order.
REQ-039 rst asserted at count 9 with wr_en=1 -> next cycle count=0, empty=1, pointers 0, sticky flags 0.
